// File: rtl/regfile_sb.sv
// regfile_sb: 32x WIDTH MIPS32 register file with per-register pending-write scoreboard.
// Optional same-cycle write-back bypass on reads and busy flags: define REGFILE_WB_BYPASS_EN.
module regfile_sb #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [4:0]       rna,
    input  logic [4:0]       rnb,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qb,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             issue_we,
    input  logic [4:0]       issue_rn,
    output logic             issue_full,
    input  logic             wb_we,
    input  logic [4:0]       wb_rn,
    input  logic [WIDTH-1:0] wb_d,
    output logic             sb_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [WIDTH-1:0] regs [32];
    logic [CNT_W-1:0] cnt [32];
    logic [31:0] inc_v, dec_v;
    assign issue_full = issue_we && issue_rn != 5'd0 && cnt[issue_rn] == CNT_MAX
                        && !(wb_we && wb_rn == issue_rn);
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        if (issue_we && !issue_full) inc_v[issue_rn] = 1'b1;
        if (wb_we) dec_v[wb_rn] = 1'b1;
        inc_v[0] = 1'b0;
        dec_v[0] = 1'b0;
    end
    // regs[0] and cnt[0] only ever hold their reset value, so reg 0 reads as 0
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (wb_we && wb_rn != 5'd0) regs[wb_rn] <= wb_d;
            for (int r = 1; r < 32; r++) begin
                if (inc_v[r] && !dec_v[r]) cnt[r] <= cnt[r] + 1'b1;
                else if (dec_v[r] && !inc_v[r] && cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
            end
            if (dec_v[wb_rn] && !inc_v[wb_rn] && cnt[wb_rn] == '0) sb_err <= 1'b1;
        end
    end
`ifdef REGFILE_WB_BYPASS_EN
    logic hit_a, hit_b;
    assign hit_a  = wb_we && wb_rn == rna && rna != 5'd0;
    assign hit_b  = wb_we && wb_rn == rnb && rnb != 5'd0;
    assign qa     = hit_a ? wb_d : regs[rna];
    assign qb     = hit_b ? wb_d : regs[rnb];
    assign busy_a = rna != 5'd0 && cnt[rna] != '0 && !(hit_a && cnt[rna] == CNT_W'(1));
    assign busy_b = rnb != 5'd0 && cnt[rnb] != '0 && !(hit_b && cnt[rnb] == CNT_W'(1));
`else
    assign qa     = regs[rna];
    assign qb     = regs[rnb];
    assign busy_a = rna != 5'd0 && cnt[rna] != '0;
    assign busy_b = rnb != 5'd0 && cnt[rnb] != '0;
`endif
endmodule
